// File: rtl/wordcell_pkg.sv
// rtl/wordcell_pkg.sv - shared types and defaults for the Wordcell array and its controller
package wordcell_pkg;

    localparam int   DEF_WIDTH = 8;
    localparam int   DEF_ROWS  = 8;

    localparam logic OP_READ   = 1'b0;
    localparam logic OP_WRITE  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } state_t;

endpackage

// File: rtl/wordcell_row_decoder.sv
// rtl/wordcell_row_decoder.sv - combinational address to one-hot word select with enable
// Addresses at or beyond ROWS decode to all-zero, so the select can never be multi-hot.
module wordcell_row_decoder
    import wordcell_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = 3
) (
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [ROWS-1:0]   o_sel
);

    always_comb begin
        o_sel = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (i_en && (i_addr == ADDR_W'(i))) begin
                o_sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wordcell_array_ctrl.sv
// rtl/wordcell_array_ctrl.sv - request/response sequencer driving op, sel_x and in_bus of a Wordcell bank
// Array-facing outputs are registered one cycle behind the state so sel_x never toggles with op/in_bus.
module wordcell_array_ctrl
    import wordcell_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int ROWS          = DEF_ROWS,
    parameter int ADDR_W        = 3,
    parameter int STROBE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_err,
    output logic              op,
    output logic [ROWS-1:0]   sel_x,
    output logic [WIDTH-1:0]  in_bus,
    input  logic [WIDTH-1:0]  out_bus
);

    localparam int               CNT_W    = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [31:0]      ROWS_U   = 32'(ROWS);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [WIDTH-1:0]   r_wdata;
    logic               r_op;
    logic [ROWS-1:0]    r_sel;
    logic [WIDTH-1:0]   r_in_bus;
    logic               r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_rdata;
    logic               r_rsp_err;

    logic               w_accept;
    logic               w_addr_err;
    logic               w_strobe_last;
    logic               w_rsp_done;
    logic               w_dec_en;
    logic               w_op_next;
    logic [WIDTH-1:0]   w_in_bus_next;
    logic [ROWS-1:0]    w_sel_next;

    assign req_ready     = (r_state == IDLE) && !rst;
    assign w_accept      = req_valid && req_ready;
    assign w_addr_err    = (32'(req_addr) >= ROWS_U);
    assign w_strobe_last = (r_state == STROBE) && (r_cnt == CNT_LAST);
    assign w_rsp_done    = r_rsp_valid && rsp_ready;
    assign w_dec_en      = (r_state == STROBE);

    wordcell_row_decoder #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_row_decoder (
        .i_en   (w_dec_en),
        .i_addr (r_addr),
        .o_sel  (w_sel_next)
    );

    always_comb begin
        w_state_next  = r_state;
        w_op_next     = OP_READ;
        w_in_bus_next = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_addr_err ? RESP : SETUP;
                end
            end
            SETUP: begin
                w_op_next     = r_we;
                w_in_bus_next = r_we ? r_wdata : '0;
                w_state_next  = STROBE;
            end
            STROBE: begin
                w_op_next     = r_we;
                w_in_bus_next = r_we ? r_wdata : '0;
                if (r_cnt == CNT_LAST) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                w_op_next     = r_we;
                w_in_bus_next = r_we ? r_wdata : '0;
                w_state_next  = RESP;
            end
            RESP: begin
                if (w_rsp_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_we        <= OP_READ;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_op        <= OP_READ;
            r_sel       <= '0;
            r_in_bus    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_op     <= w_op_next;
            r_in_bus <= w_in_bus_next;
            r_sel    <= w_sel_next;
            r_cnt    <= ((r_state == STROBE) && !w_strobe_last) ? r_cnt + 1'b1 : '0;

            if (w_accept) begin
                r_we        <= req_we;
                r_addr      <= req_addr;
                r_wdata     <= req_wdata;
                r_rsp_rdata <= '0;
                r_rsp_err   <= w_addr_err;
            end else if (w_strobe_last && !r_we) begin
                r_rsp_rdata <= out_bus;
            end

            // Error responses skip the array and are valid the cycle RESP is entered.
            if (w_accept && w_addr_err) begin
                r_rsp_valid <= 1'b1;
            end else if ((r_state == RESP) && !r_rsp_valid) begin
                r_rsp_valid <= 1'b1;
            end else if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign op        = r_op;
    assign sel_x     = r_sel;
    assign in_bus    = r_in_bus;

endmodule

// File: tb/tb_wordcell_array_ctrl.sv
// tb/tb_wordcell_array_ctrl.sv - directed bench for wordcell_array_ctrl with a behavioural latch array
module tb_wordcell_array_ctrl;

    localparam int W  = 8;
    localparam int R  = 8;
    localparam int AW = 3;
    localparam int SC = 2;
    localparam int RB = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [W-1:0]  rsp_rdata;
    logic          op;
    logic [R-1:0]  sel_x;
    logic [W-1:0]  in_bus, out_bus;

    logic          b_req_valid, b_req_ready, b_req_we;
    logic [AW-1:0] b_req_addr;
    logic [W-1:0]  b_req_wdata;
    logic          b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [W-1:0]  b_rsp_rdata;
    logic          b_op;
    logic [RB-1:0] b_sel_x;
    logic [W-1:0]  b_in_bus, b_out_bus;

    int total = 0;
    int bad   = 0;

    wordcell_array_ctrl #(.WIDTH(W), .ROWS(R), .ADDR_W(AW), .STROBE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .op(op), .sel_x(sel_x), .in_bus(in_bus), .out_bus(out_bus)
    );

    wordcell_array_ctrl #(.WIDTH(W), .ROWS(RB), .ADDR_W(AW), .STROBE_CYCLES(SC)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .op(b_op), .sel_x(b_sel_x), .in_bus(b_in_bus), .out_bus(b_out_bus)
    );

    assign b_out_bus = '0;

    // Behavioural bank: each word latches in_bus while selected with op=1, drives out_bus while selected.
    logic [W-1:0] mem [R];
    always @(posedge clk) begin
        for (int i = 0; i < R; i++) begin
            if (op && sel_x[i]) mem[i] <= in_bus;
        end
    end
    always_comb begin
        out_bus = '0;
        for (int i = 0; i < R; i++) begin
            if (sel_x[i]) out_bus = out_bus | mem[i];
        end
    end

    logic         mon_en = 1'b0;
    int           viol_hot = 0, viol_stab = 0, sel_cnt = 0, op_cnt = 0, b_sel_cnt = 0;
    logic [R-1:0] sel_seen, p_sel;
    logic [W-1:0] in_seen, p_in;
    logic         p_op;

    always @(negedge clk) begin
        if (mon_en) begin
            if ($countones(sel_x) > 1) viol_hot++;
            if (((sel_x != 0) || (p_sel != 0)) && ((op !== p_op) || (in_bus !== p_in))) viol_stab++;
            if (b_sel_x != 0) b_sel_cnt++;
        end
        if (sel_x != 0) begin
            sel_cnt++;
            sel_seen = sel_x;
            in_seen  = in_bus;
        end
        if (op === 1'b1) op_cnt++;
        p_op  = op;
        p_sel = sel_x;
        p_in  = in_bus;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one request on the main instance; with hold=1 returns at the first rsp_valid sample with rsp_ready low.
    task automatic xact(input string tag, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d,
                        input logic hold, output logic [W-1:0] rd, output logic er, output int lat);
        int n;
        n = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        rsp_ready = !hold;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk({tag, "_accept_timeout"}, 0, 1);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        rd = rsp_rdata;
        er = rsp_err;
        if (!hold) @(negedge clk);
    endtask

    task automatic b_xact(input string tag, input logic [AW-1:0] a, input logic exp_err, input int exp_lat);
        int n, lat, s0;
        n = 0;
        s0 = b_sel_cnt;
        b_req_valid = 1'b1; b_req_addr = a; b_rsp_ready = 1'b1;
        while (!b_req_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk({tag, "_accept_timeout"}, 0, 1);
        @(negedge clk);
        b_req_valid = 1'b0;
        lat = 0;
        while (!b_rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_err"}, b_rsp_err, exp_err);
        chk({tag, "_rdata"}, b_rsp_rdata, 0);
        chk({tag, "_sel_cycles"}, b_sel_cnt - s0, exp_err ? 0 : SC);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rd;
        logic         er;
        int           lat, s0, o0, n;

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_op", op, 0);
        chk("rst_sel_x", sel_x, 0);
        chk("rst_in_bus", in_bus, 0);
        chk("idle_req_ready", req_ready, 1);
        mon_en = 1'b1;

        s0 = sel_cnt; o0 = op_cnt;
        xact("wr3", 1'b1, 3'd3, 8'h55, 1'b0, rd, er, lat);
        chk("wr3_lat", lat, 5);
        chk("wr3_err", er, 0);
        chk("wr3_sel_cycles", sel_cnt - s0, 2);
        chk("wr3_sel", sel_seen, 8'b0000_1000);
        chk("wr3_in_bus", in_seen, 8'h55);
        chk("wr3_op_cycles", op_cnt - o0, 4);

        s0 = sel_cnt; o0 = op_cnt;
        xact("rd3", 1'b0, 3'd3, 8'h00, 1'b0, rd, er, lat);
        chk("rd3_lat", lat, 5);
        chk("rd3_rdata", rd, 8'h55);
        chk("rd3_sel_cycles", sel_cnt - s0, 2);
        chk("rd3_sel", sel_seen, 8'b0000_1000);
        chk("rd3_in_bus", in_seen, 8'h00);
        chk("rd3_op_cycles", op_cnt - o0, 0);

        xact("wr0", 1'b1, 3'd0, 8'hCC, 1'b0, rd, er, lat);
        chk("wr0_sel", sel_seen, 8'b0000_0001);
        chk("wr0_rdata", rd, 8'h00);
        xact("rd0", 1'b0, 3'd0, 8'h00, 1'b0, rd, er, lat);
        chk("rd0_rdata", rd, 8'hCC);
        xact("rd3b", 1'b0, 3'd3, 8'h00, 1'b0, rd, er, lat);
        chk("rd3b_rdata", rd, 8'h55);

        xact("bp", 1'b0, 3'd0, 8'h00, 1'b1, rd, er, lat);
        chk("bp_rdata0", rd, 8'hCC);
        chk("bp_req_ready0", req_ready, 0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rdata", rsp_rdata, 8'hCC);
            chk("bp_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3;
        chk("bp_release_req_ready", req_ready, 0);
        @(negedge clk);
        chk("bp_after_rsp_valid", rsp_valid, 0);
        chk("bp_after_req_ready", req_ready, 1);
        xact("rd3c", 1'b0, 3'd3, 8'h00, 1'b0, rd, er, lat);
        chk("rd3c_lat", lat, 5);
        chk("rd3c_rdata", rd, 8'h55);

        b_xact("b_addr7", 3'd7, 1'b1, 0);
        b_xact("b_addr6", 3'd6, 1'b1, 0);
        b_xact("b_addr5", 3'd5, 1'b0, 5);

        mon_en = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd5; req_wdata = 8'hA5; rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        while (sel_x == 0 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("rstmid_strobe_timeout", 0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_sel_x", sel_x, 0);
        chk("rstmid_op", op, 0);
        chk("rstmid_in_bus", in_bus, 0);
        chk("rstmid_rsp_valid", rsp_valid, 0);
        chk("rstmid_req_ready", req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_req_ready_after", req_ready, 1);
        mon_en = 1'b1;
        xact("rd3d", 1'b0, 3'd3, 8'h00, 1'b0, rd, er, lat);
        chk("rd3d_rdata", rd, 8'h55);
        xact("rd0d", 1'b0, 3'd0, 8'h00, 1'b0, rd, er, lat);
        chk("rd0d_rdata", rd, 8'hCC);

        chk("sel_onehot", viol_hot, 0);
        chk("sel_stable", viol_stab, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
